// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with debounced button, cause capture and optional watchdog
// Optional watchdog is compiled in with RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int N_OUT           = 3,
    parameter int STRETCH         = 8,
    parameter int STAGE_GAP       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int WDT_CYCLES      = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_i,
    input  logic             wdt_kick_i,
    output logic [N_OUT-1:0] rst_o,
    output logic             done_o,
    output logic [1:0]       cause_o
);

    localparam int SEQ_MAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SEQ_W-1:0] STRETCH_LAST = SEQ_W'(STRETCH - 1);
    localparam logic [SEQ_W-1:0] GAP_LAST     = SEQ_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level that means "not pressed"
    localparam logic             BTN_IDLE     = (BTN_ACTIVE_LOW != 0);

    localparam logic [1:0] CAUSE_POWER  = 2'd0;
    localparam logic [1:0] CAUSE_BUTTON = 2'd1;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RELEASE  = 2'd1,
        RUN      = 2'd2,
        BTN_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N_OUT-1:0] rst_q, rst_d;
    logic [1:0]       cause_q, cause_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             btn_s1_q, btn_s1_d;
    logic             btn_s2_q, btn_s2_d;
    logic             deb_q, deb_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             btn_pressed_s;
    logic [N_OUT-1:0] rst_shift;

    assign btn_pressed_s = (btn_s2_q != BTN_IDLE);
    assign rst_shift     = rst_q << 1;

    // Synchroniser and debounce, in the "pressed = 1" domain after stage 2
    always_comb begin
        btn_s1_d = btn_i;
        btn_s2_d = btn_s1_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (btn_pressed_s != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int                WDT_W        = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0]  WDT_MAX      = WDT_W'(WDT_CYCLES);
    localparam logic [1:0]        CAUSE_WDT    = 2'd2;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick_i ^ (WDT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        rst_d     = rst_q;
        cause_d   = cause_q;
        seq_cnt_d = seq_cnt_q;
`ifdef RESET_SEQ_WDT_EN
        wdt_cnt_d = '0;
`endif
        unique case (state_q)
            HOLD, RELEASE: begin
                if (deb_q) begin
                    state_d   = BTN_WAIT;
                    rst_d     = '1;
                    cause_d   = CAUSE_BUTTON;
                    seq_cnt_d = '0;
                end else if (seq_cnt_q == ((state_q == HOLD) ? STRETCH_LAST : GAP_LAST)) begin
                    rst_d     = rst_shift;
                    seq_cnt_d = '0;
                    state_d   = (rst_shift == '0) ? RUN : RELEASE;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            RUN: begin
                if (deb_q) begin
                    state_d   = BTN_WAIT;
                    rst_d     = '1;
                    cause_d   = CAUSE_BUTTON;
                    seq_cnt_d = '0;
                end
`ifdef RESET_SEQ_WDT_EN
                else if (wdt_kick_i) begin
                    wdt_cnt_d = '0;
                end else if (wdt_cnt_q == WDT_MAX) begin
                    state_d   = HOLD;
                    rst_d     = '1;
                    cause_d   = CAUSE_WDT;
                    seq_cnt_d = '0;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
                end
`endif
            end
            BTN_WAIT: begin
                rst_d = '1;
                if (!deb_q) begin
                    state_d   = HOLD;
                    seq_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            rst_q     <= '1;
            cause_q   <= CAUSE_POWER;
            seq_cnt_q <= '0;
            btn_s1_q  <= BTN_IDLE;
            btn_s2_q  <= BTN_IDLE;
            deb_q     <= 1'b0;
            db_cnt_q  <= '0;
`ifdef RESET_SEQ_WDT_EN
            wdt_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rst_q     <= rst_d;
            cause_q   <= cause_d;
            seq_cnt_q <= seq_cnt_d;
            btn_s1_q  <= btn_s1_d;
            btn_s2_q  <= btn_s2_d;
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
`ifdef RESET_SEQ_WDT_EN
            wdt_cnt_q <= wdt_cnt_d;
`endif
        end
    end

    assign rst_o   = rst_q;
    assign done_o  = (state_q == RUN);
    assign cause_o = cause_q;

endmodule
